// File: rtl/commutator_route_loader.sv
// commutator_route_loader
// Buffers route writes ("output channel N takes input S") in a small FIFO and
// replays each one onto the commutator's shared control bus with a one-hot
// load strobe framed by setup and hold phases.
// Optional feature macro: ROUTE_READBACK_EN adds a route_table shadow output.
//
// state  | meaning
// IDLE   | waiting for a queued route write
// SETUP  | ld_control driven, strobe low
// STROBE | ld_strobe[chan] high, commutator storage transparent
// HOLD   | strobe low, ld_control still held
module commutator_route_loader #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [1:0]                    wr_chan,
    input  logic [2:0]                    wr_src,
    output logic [2:0]                    ld_control,
    output logic [2:0]                    ld_strobe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_chan
`ifdef ROUTE_READBACK_EN
    ,
    output logic [8:0]                    route_table
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAX1 = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAXC = (MAX1 > HOLD_CYCLES) ? MAX1 : HOLD_CYCLES;
    // Down-counter holds N-1 .. 0 for the longest phase
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      chan_q;
    logic [4:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      head_chan;
    logic [2:0]      head_src;

    assign wr_ready  = (fifo_level != LW'(FIFO_DEPTH));
    assign accept    = wr_valid && wr_ready;
    // Illegal channel 3 is consumed by the handshake but never queued
    assign push      = accept && (wr_chan != 2'd3);
    assign pop       = (state == IDLE) && (fifo_level != '0);
    assign head_chan = mem[rd_ptr][4:3];
    assign head_src  = mem[rd_ptr][2:0];
    assign busy      = (state != IDLE) || (fifo_level != '0);

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_chan, wr_src};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky illegal-channel flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chan <= 1'b0;
        end else if (accept && (wr_chan == 2'd3)) begin
            err_chan <= 1'b1;
        end
    end

    // Sequencer: pop, setup, strobe, hold with registered control and strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            chan_q     <= '0;
            ld_control <= '0;
            ld_strobe  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= SETUP;
                        cnt        <= CW'(SETUP_CYCLES - 1);
                        chan_q     <= head_chan;
                        // Commutator mux select lines are wired MSB-first
                        ld_control <= {head_src[0], head_src[1], head_src[2]};
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state     <= STROBE;
                        cnt       <= CW'(STROBE_CYCLES - 1);
                        ld_strobe <= 3'b001 << chan_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        cnt       <= CW'(HOLD_CYCLES - 1);
                        ld_strobe <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROUTE_READBACK_EN
    logic [2:0] src_q;

    // Natural-binary copy of the source being loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else if (pop) begin
            src_q <= head_src;
        end
    end

    // Shadow table commits when the strobe phase for a channel ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_table <= '0;
        end else if ((state == STROBE) && (cnt == '0)) begin
            case (chan_q)
                2'd0:    route_table[2:0] <= src_q;
                2'd1:    route_table[5:3] <= src_q;
                2'd2:    route_table[8:6] <= src_q;
                default: route_table      <= route_table;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_commutator_route_loader.sv
// Testbench for commutator_route_loader: transaction-level reference model
// (queue of pending routes plus the age of the active load), compared every
// cycle, with directed scenarios carrying literal expectations.
module tb_commutator_route_loader;

    localparam int S   = 1;
    localparam int ST  = 2;
    localparam int H   = 1;
    localparam int TOT = S + ST + H;
    localparam int D   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_chan = '0;
    logic [2:0] wr_src = '0;
    logic       wr_ready;
    logic [2:0] ld_control;
    logic [2:0] ld_strobe;
    logic       busy;
    logic [2:0] fifo_level;
    logic       err_chan;
`ifdef ROUTE_READBACK_EN
    logic [8:0] route_table;
`endif

    commutator_route_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_chan    (wr_chan),
        .wr_src     (wr_src),
        .ld_control (ld_control),
        .ld_strobe  (ld_strobe),
        .busy       (busy),
        .fifo_level (fifo_level),
        .err_chan   (err_chan)
`ifdef ROUTE_READBACK_EN
        ,
        .route_table(route_table)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {logic [1:0] c; logic [2:0] s;} ent_t;
    ent_t       q[$];
    logic       m_active = 1'b0;
    int         m_age = 0;
    logic [1:0] m_chan = '0;
    logic [2:0] m_src = '0;
    logic [2:0] m_ctrl = '0;
    logic       m_err = 1'b0;
    logic [8:0] m_rt = '0;

    always @(posedge clk or negedge rst_n) begin
        bit   rdy;
        bit   do_pop;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_ctrl   = '0;
            m_err    = 1'b0;
            m_rt     = '0;
        end else begin
            rdy    = (q.size() != D);
            do_pop = !m_active && (q.size() > 0);
            if (m_active) begin
                m_age++;
                if (m_age == S + ST) m_rt[3*m_chan +: 3] = m_src;
                if (m_age == TOT) m_active = 1'b0;
            end
            if (do_pop) begin
                e        = q.pop_front();
                m_active = 1'b1;
                m_age    = 0;
                m_chan   = e.c;
                m_src    = e.s;
                m_ctrl   = {e.s[0], e.s[1], e.s[2]};
            end
            if (wr_valid && rdy) begin
                if (wr_chan == 2'd3) m_err = 1'b1;
                else q.push_back({wr_chan, wr_src});
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         rises[$];
    logic [2:0] prev_strobe = '0;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int exp_strobe;
        exp_strobe = (m_active && m_age >= S && m_age < S + ST) ? (1 << m_chan) : 0;
        chk("wr_ready",   wr_ready,   (q.size() != D) ? 1 : 0);
        chk("fifo_level", fifo_level, q.size());
        chk("busy",       busy,       (m_active || q.size() != 0) ? 1 : 0);
        chk("err_chan",   err_chan,   m_err);
        chk("ld_control", ld_control, m_ctrl);
        chk("ld_strobe",  ld_strobe,  exp_strobe);
        chk("strobe_onehot0", $onehot0(ld_strobe) ? 1 : 0, 1);
`ifdef ROUTE_READBACK_EN
        chk("route_table", route_table, m_rt);
`endif
        if (ld_strobe != 3'b000 && prev_strobe == 3'b000) rises.push_back(cyc);
        prev_strobe = ld_strobe;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [2:0] s);
        wr_valid = 1'b1;
        wr_chan  = c;
        wr_src   = s;
    endtask

    initial begin
        int cnt;
        int sent;
        int iter;
        bit saw_full;
        bit rdy;

        repeat (3) step();
        chk("rst_ready",   wr_ready,   1);
        chk("rst_control", ld_control, 0);
        chk("rst_strobe",  ld_strobe,  0);
        chk("rst_busy",    busy,       0);
        chk("rst_level",   fifo_level, 0);
        chk("rst_err",     err_chan,   0);
        rst_n = 1'b1;
        step();

        // single write chan=1 src=5
        drive(2'd1, 3'd5);
        step();                               // E0
        wr_valid = 1'b0;
        step();                               // E1
        chk("t1_ctrl_e1", ld_control, 3'b101);
        chk("t1_strobe_e1", ld_strobe, 3'b000);
        step();                               // E2
        chk("t1_strobe_e2", ld_strobe, 3'b010);
        step();                               // E3
        chk("t1_strobe_e3", ld_strobe, 3'b010);
        step();                               // E4
        chk("t1_strobe_e4", ld_strobe, 3'b000);
`ifdef ROUTE_READBACK_EN
        chk("t1_route", route_table[5:3], 5);
`endif
        step();                               // E5
        chk("t1_busy_e5", busy, 0);
        repeat (2) step();

        // chan=0 src=1: reversed control, strobe exactly 2 cycles
        drive(2'd0, 3'd1);
        step();
        wr_valid = 1'b0;
        step();
        chk("t2_ctrl", ld_control, 3'b100);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ld_strobe == 3'b001) cnt++;
            chk("t2_ctrl_stable", ld_control, 3'b100);
        end
        chk("t2_strobe_len", cnt, 2);
        repeat (2) step();

        // burst of 6 with wr_valid held
        rises.delete();
        sent = 0;
        iter = 0;
        saw_full = 0;
        while (sent < 6 && iter < 60) begin
            drive(2'(sent % 3), 3'(sent + 2));
            rdy = wr_ready;
            if (!rdy && !saw_full) begin
                chk("burst_full_level", fifo_level, 4);
                saw_full = 1;
            end
            step();
            if (rdy) sent++;
            iter++;
        end
        wr_valid = 1'b0;
        chk("burst_sent", sent, 6);
        chk("burst_saw_full", saw_full, 1);
        repeat (40) step();
        chk("burst_rises", rises.size(), 6);
        for (int i = 1; i < rises.size(); i++) chk("burst_gap", rises[i] - rises[i-1], 5);

        // illegal channel, then a legal write
        drive(2'd3, 3'd2);
        chk("ill_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        chk("ill_err", err_chan, 1);
        chk("ill_level", fifo_level, 0);
        rises.delete();
        repeat (4) step();
        chk("ill_no_strobe", rises.size(), 0);
        drive(2'd2, 3'd3);
        step();
        wr_valid = 1'b0;
        step();
        chk("ill_next_ctrl", ld_control, 3'b110);
        step();
        chk("ill_next_strobe", ld_strobe, 3'b100);
        repeat (6) step();

        // simultaneous push and pop at level 2
        drive(2'd0, 3'd6);  step();           // E0
        drive(2'd1, 3'd7);  step();           // E1 pop A, push B
        drive(2'd2, 3'd0);  step();           // E2
        chk("pp_level_pre", fifo_level, 2);
        wr_valid = 1'b0;
        repeat (3) step();                    // E3..E5
        drive(2'd1, 3'd4);  step();           // E6 pop B, push D
        wr_valid = 1'b0;
        chk("pp_level", fifo_level, 2);
        chk("pp_ctrl_b", ld_control, 3'b111);
        repeat (20) step();

        // reset during STROBE with 2 entries queued
        drive(2'd0, 3'd1);  step();
        drive(2'd1, 3'd2);  step();
        drive(2'd2, 3'd3);  step();
        wr_valid = 1'b0;
        chk("mr_strobe_pre", ld_strobe, 3'b001);
        chk("mr_level_pre", fifo_level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_strobe", ld_strobe, 0);
        chk("mr_level", fifo_level, 0);
        step();
        rst_n = 1'b1;
        rises.delete();
        repeat (10) step();
        chk("mr_no_strobe", rises.size(), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_chan  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wr_src   = 3'($urandom_range(0, 7));
            if (i == 300) begin
                #3;
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end
        wr_valid = 1'b0;
        repeat (40) step();
        chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commutator_route_loader.md
Name: commutator_route_loader

Overview:
- Upstream programming stage for the 5-to-3 commutator.
- Accepts route writes of the form "output channel N takes input index S" over a valid/ready handshake and buffers them in a small FIFO.
- Replays each write onto the commutator's shared 3-bit control bus with a one-hot load strobe, using setup / strobe / hold phases. The strobe phase covers the commutator's level-sensitive storage.
- Bit-reverses the source index so that the commutator mux selects input S.

Parameters:
FIFO_DEPTH, 4, route-write buffer entries; power of two, >=2
SETUP_CYCLES, 1, cycles ld_control is stable before the strobe rises; >=1
STROBE_CYCLES, 2, cycles the strobe is held high; >=1
HOLD_CYCLES, 1, cycles ld_control is held after the strobe falls; >=1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  route write request
wr_ready  output  1  loader can accept a write
wr_chan  input  2  target output channel 0..2; value 3 is illegal
wr_src  input  3  source input index 0..7, natural binary
ld_control  output  3  to commutator control bus, bit-reversed wr_src
ld_strobe  output  3  to commutator per-channel load clocks, one-hot or zero
busy  output  1  FIFO non-empty or FSM not in IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
err_chan  output  1  sticky flag: an illegal wr_chan was received

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous and active-low; all state clears immediately on assertion.
  - Release of rst_n is synchronous to clk.
- Reset values:
  - ld_control=0, ld_strobe=0, busy=0, fifo_level=0, err_chan=0, wr_ready=1.
  - FSM in IDLE, FIFO empty.
- Handshake:
  - A write transfers on a rising edge with wr_valid && wr_ready.
  - wr_ready = (fifo_level != FIFO_DEPTH); it is combinational from occupancy only.
- Illegal channel:
  - A transfer with wr_chan==3 is consumed but not queued; fifo_level is unchanged.
  - err_chan is set on that edge and is cleared only by reset.
- FIFO:
  - Entries are {chan, src}, first-in first-out.
  - Push and pop on the same edge leave fifo_level unchanged.
  - No push is possible while full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP when the FIFO is non-empty. On that edge:
    - pop the head entry;
    - ld_control <= {src[0],src[1],src[2]};
    - latch chan.
  - SETUP:
    - ld_strobe=0.
    - After SETUP_CYCLES cycles, go to STROBE.
  - STROBE:
    - ld_strobe[chan]=1, all other strobe bits 0.
    - After STROBE_CYCLES cycles, go to HOLD.
  - HOLD:
    - ld_strobe=0; ld_control unchanged.
    - After HOLD_CYCLES cycles, go to IDLE.
  - After completion, ld_control retains its last value and is not cleared.
  - One write is processed per sequence; there is no back-to-back overlap. The minimum spacing is 1+SETUP+STROBE+HOLD cycles per entry.
- Outputs:
  - ld_strobe and ld_control are registered outputs; they never glitch.
  - ld_control never changes while any ld_strobe bit is high.
- Latency with defaults (write at edge E0, FIFO empty, FSM IDLE):
  - ld_control valid after E1.
  - ld_strobe[chan] high after E2 and low after E4.
  - FSM reaches IDLE after E5; busy=0 after E5 if no further writes.
- busy = (state != IDLE) || (fifo_level != 0).
- Reset mid-sequence:
  - The strobe drops immediately and the FIFO contents are discarded.
  - The commutator keeps its last latched routes.

Optional Feature:
- Macro: ROUTE_READBACK_EN.
- Defined:
  - Adds output route_table [8:0], which is a shadow of the programmed routes, natural-binary source indices.
  - route_table[3c+2:3c] is updated with src when the STROBE phase for channel c ends.
  - Reset value is 0.
- Undefined:
  - No route_table port and no shadow registers.
  - All other behaviour is identical.

Test Plan:
- Reset, then a single write chan=1, src=5:
  - ld_control=3'b101 after E1.
  - ld_strobe=3'b010 during cycles E2..E4.
  - busy low after E5.
  - route_table[5:3]=5 when ROUTE_READBACK_EN is defined.
- Write chan=0, src=1:
  - ld_control=3'b100 (bit-reversed); strobe 3'b001 for exactly 2 cycles.
  - ld_control stable from SETUP through HOLD.
- Burst of 6 writes with wr_valid held high:
  - wr_ready falls when fifo_level=4.
  - All 6 sequences emitted in order, spaced 5 cycles apart.
  - No strobe overlap.
- Write chan=3, src=2:
  - Accepted (wr_ready=1), err_chan=1, fifo_level stays 0, no strobe.
  - A following legal write is processed normally.
- Assert rst_n low during STROBE with 2 entries queued:
  - ld_strobe=0 immediately; fifo_level=0; no further strobes after release.
- Simultaneous push and pop with fifo_level=2:
  - fifo_level remains 2; entry order preserved.
